// File: rtl/issue_queue_pkg.sv
// rtl/issue_queue_pkg.sv - shared widths, operand types and CDB snoop helper for the issue queue
package issue_queue_pkg;

    localparam int DEF_TAG_W     = 6;
    localparam int DEF_PAYLOAD_W = 170;
    localparam int OPND_W        = 32;

    typedef logic [OPND_W-1:0] opnd_t;

    typedef struct packed {
        logic  rdy;
        opnd_t val;
    } opnd_st_t;

    // A source already holding its value ignores the bus; otherwise a tag hit captures the broadcast.
    function automatic opnd_st_t snoop(input logic rdy, input opnd_t val,
                                       input logic hit, input opnd_t cdb_val);
        opnd_st_t r;
        r.rdy = rdy | hit;
        r.val = (!rdy && hit) ? cdb_val : val;
        return r;
    endfunction

endpackage

// File: rtl/issue_queue_if.sv
// rtl/issue_queue_if.sv - dispatch, CDB and issue bundle between the issue queue and its neighbours
interface issue_queue_if
    import issue_queue_pkg::*;
#(
    parameter int TAG_W     = DEF_TAG_W,
    parameter int PAYLOAD_W = DEF_PAYLOAD_W
);
    logic                 dispatch_valid;
    logic                 dispatch_ready;
    logic [PAYLOAD_W-1:0] dispatch_payload;
    logic [TAG_W-1:0]     dispatch_srcA_tag;
    logic                 dispatch_srcA_rdy;
    opnd_t                dispatch_srcA_val;
    logic [TAG_W-1:0]     dispatch_srcB_tag;
    logic                 dispatch_srcB_rdy;
    opnd_t                dispatch_srcB_val;

    logic                 cdb_valid;
    logic [TAG_W-1:0]     cdb_tag;
    opnd_t                cdb_value;

    logic                 issue_stall;
    logic                 issue_valid;
    logic [PAYLOAD_W-1:0] issue_payload;
    opnd_t                issue_opA;
    opnd_t                issue_opB;

    modport slave (
        input  dispatch_valid, dispatch_payload,
        input  dispatch_srcA_tag, dispatch_srcA_rdy, dispatch_srcA_val,
        input  dispatch_srcB_tag, dispatch_srcB_rdy, dispatch_srcB_val,
        output dispatch_ready,
        input  cdb_valid, cdb_tag, cdb_value,
        input  issue_stall,
        output issue_valid, issue_payload, issue_opA, issue_opB
    );

    modport master (
        output dispatch_valid, dispatch_payload,
        output dispatch_srcA_tag, dispatch_srcA_rdy, dispatch_srcA_val,
        output dispatch_srcB_tag, dispatch_srcB_rdy, dispatch_srcB_val,
        input  dispatch_ready,
        output cdb_valid, cdb_tag, cdb_value,
        output issue_stall,
        input  issue_valid, issue_payload, issue_opA, issue_opB
    );
endinterface

// File: rtl/issue_queue_select.sv
// rtl/issue_queue_select.sv - lowest-index-first priority encoder over a request vector
module iq_select #(
    parameter int  N     = 8,
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    output logic             found,
    output logic [IDX_W-1:0] idx
);
    always_comb begin
        found = 1'b0;
        idx   = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                found = 1'b1;
                idx   = IDX_W'(i);
            end
        end
    end
endmodule

// File: rtl/issue_queue.sv
// rtl/issue_queue.sv - collapsing age-ordered issue queue with CDB wakeup and a registered issue port
module issue_queue
    import issue_queue_pkg::*;
#(
    parameter int DEPTH     = 8,
    parameter int TAG_W     = DEF_TAG_W,
    parameter int PAYLOAD_W = DEF_PAYLOAD_W
) (
    input  logic                       CLK,
    input  logic                       RESET,
    input  logic                       flush,
    issue_queue_if.slave               bus,
    output logic [$clog2(DEPTH+1)-1:0] occupancy
);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DEPTH-1:0]     vld, a_rdy, b_rdy;
    logic [PAYLOAD_W-1:0] pl    [DEPTH];
    logic [TAG_W-1:0]     a_tag [DEPTH];
    logic [TAG_W-1:0]     b_tag [DEPTH];
    opnd_t                a_val [DEPTH];
    opnd_t                b_val [DEPTH];
    logic [CNT_W-1:0]     count;

    logic [DEPTH-1:0]     n_vld, n_a_rdy, n_b_rdy;
    logic [PAYLOAD_W-1:0] n_pl    [DEPTH];
    logic [TAG_W-1:0]     n_a_tag [DEPTH];
    logic [TAG_W-1:0]     n_b_tag [DEPTH];
    opnd_t                n_a_val [DEPTH];
    opnd_t                n_b_val [DEPTH];

    logic [DEPTH-1:0]     w_a_rdy, w_b_rdy;
    opnd_t                w_a_val [DEPTH];
    opnd_t                w_b_val [DEPTH];
    logic                 d_a_rdy, d_b_rdy;
    opnd_t                d_a_val, d_b_val;

    logic                 iss_valid;
    logic [PAYLOAD_W-1:0] iss_payload;
    opnd_t                iss_opa, iss_opb;

    logic [DEPTH-1:0]     ready_vec;
    logic                 sel_found, do_issue, accept;
    logic [IDX_W-1:0]     sel_idx;
    logic [CNT_W-1:0]     wpos;

    // Selection sees only registered readiness, so a source woken this cycle issues no earlier than next cycle.
    assign ready_vec = vld & a_rdy & b_rdy;

    iq_select #(.N(DEPTH)) u_select (
        .req   (ready_vec),
        .found (sel_found),
        .idx   (sel_idx)
    );

    assign bus.dispatch_ready = (count != CNT_W'(DEPTH));
    assign do_issue           = !bus.issue_stall && sel_found;
    assign accept             = bus.dispatch_valid && bus.dispatch_ready;
    assign wpos               = count - CNT_W'(do_issue);

    assign {d_a_rdy, d_a_val} = snoop(bus.dispatch_srcA_rdy, bus.dispatch_srcA_val,
                                      bus.cdb_valid && (bus.dispatch_srcA_tag == bus.cdb_tag), bus.cdb_value);
    assign {d_b_rdy, d_b_val} = snoop(bus.dispatch_srcB_rdy, bus.dispatch_srcB_val,
                                      bus.cdb_valid && (bus.dispatch_srcB_tag == bus.cdb_tag), bus.cdb_value);

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            {w_a_rdy[i], w_a_val[i]} = snoop(a_rdy[i], a_val[i],
                                             bus.cdb_valid && (a_tag[i] == bus.cdb_tag), bus.cdb_value);
            {w_b_rdy[i], w_b_val[i]} = snoop(b_rdy[i], b_val[i],
                                             bus.cdb_valid && (b_tag[i] == bus.cdb_tag), bus.cdb_value);
        end
    end

    // Wake first, then collapse entries above the issued slot, then place the dispatch at the new tail.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            n_vld[i]   = vld[i];
            n_pl[i]    = pl[i];
            n_a_rdy[i] = w_a_rdy[i];
            n_a_tag[i] = a_tag[i];
            n_a_val[i] = w_a_val[i];
            n_b_rdy[i] = w_b_rdy[i];
            n_b_tag[i] = b_tag[i];
            n_b_val[i] = w_b_val[i];
        end
        if (do_issue) begin
            for (int i = 0; i < DEPTH - 1; i++) begin
                if (sel_idx <= IDX_W'(i)) begin
                    n_vld[i]   = vld[i+1];
                    n_pl[i]    = pl[i+1];
                    n_a_rdy[i] = w_a_rdy[i+1];
                    n_a_tag[i] = a_tag[i+1];
                    n_a_val[i] = w_a_val[i+1];
                    n_b_rdy[i] = w_b_rdy[i+1];
                    n_b_tag[i] = b_tag[i+1];
                    n_b_val[i] = w_b_val[i+1];
                end
            end
            n_vld[DEPTH-1] = 1'b0;
        end
        for (int i = 0; i < DEPTH; i++) begin
            if (accept && (wpos == CNT_W'(i))) begin
                n_vld[i]   = 1'b1;
                n_pl[i]    = bus.dispatch_payload;
                n_a_rdy[i] = d_a_rdy;
                n_a_tag[i] = bus.dispatch_srcA_tag;
                n_a_val[i] = d_a_val;
                n_b_rdy[i] = d_b_rdy;
                n_b_tag[i] = bus.dispatch_srcB_tag;
                n_b_val[i] = d_b_val;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET || flush) begin
            vld   <= '0;
            count <= '0;
        end else begin
            vld   <= n_vld;
            count <= count + CNT_W'(accept) - CNT_W'(do_issue);
        end
        pl    <= n_pl;
        a_rdy <= n_a_rdy;
        a_tag <= n_a_tag;
        a_val <= n_a_val;
        b_rdy <= n_b_rdy;
        b_tag <= n_b_tag;
        b_val <= n_b_val;
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            iss_valid   <= 1'b0;
            iss_payload <= '0;
            iss_opa     <= '0;
            iss_opb     <= '0;
        end else if (flush) begin
            iss_valid <= 1'b0;
        end else if (!bus.issue_stall) begin
            iss_valid <= sel_found;
            if (sel_found) begin
                iss_payload <= pl[sel_idx];
                iss_opa     <= a_val[sel_idx];
                iss_opb     <= b_val[sel_idx];
            end
        end
    end

    assign bus.issue_valid   = iss_valid;
    assign bus.issue_payload = iss_payload;
    assign bus.issue_opA     = iss_opa;
    assign bus.issue_opB     = iss_opb;
    assign occupancy         = count;

endmodule

// File: tb/tb_issue_queue.sv
// tb/tb_issue_queue.sv - directed and randomized bench for issue_queue against an age-ordered list model
module tb_issue_queue;
    import issue_queue_pkg::*;

    localparam int DEPTH = 8;
    localparam int TW    = 6;
    localparam int PW    = 170;
    localparam int CW    = 4;

    logic          CLK = 1'b0;
    logic          RESET;
    logic          flush;
    logic [CW-1:0] occupancy;

    issue_queue_if #(.TAG_W(TW), .PAYLOAD_W(PW)) bus();

    issue_queue #(.DEPTH(DEPTH), .TAG_W(TW), .PAYLOAD_W(PW)) dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .flush     (flush),
        .bus       (bus),
        .occupancy (occupancy)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [PW-1:0] pl;
        logic          a_rdy;
        logic [TW-1:0] a_tag;
        logic [31:0]   a_val;
        logic          b_rdy;
        logic [TW-1:0] b_tag;
        logic [31:0]   b_val;
    } ent_t;

    ent_t          mq[$];
    logic          m_iv;
    logic [PW-1:0] m_pl;
    logic [31:0]   m_a, m_b;
    int            errors = 0;
    int            checks = 0;
    logic [PW-1:0] last_pl;
    logic [PW-1:0] p [DEPTH];

    task automatic chk(input string tag, input logic [PW-1:0] obs, input logic [PW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [PW-1:0] rand_pl();
        logic [191:0] t;
        t = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
        return t[PW-1:0];
    endfunction

    // Reference behaviour for one clock edge, computed from the inputs currently driven.
    task automatic model_step();
        int   sel;
        bit   acc;
        ent_t e;
        if (RESET) begin
            mq.delete();
            m_iv = 1'b0; m_pl = '0; m_a = '0; m_b = '0;
        end else if (flush) begin
            mq.delete();
            m_iv = 1'b0;
        end else begin
            sel = -1;
            if (!bus.issue_stall) begin
                for (int i = 0; i < mq.size(); i++)
                    if (sel < 0 && mq[i].a_rdy && mq[i].b_rdy) sel = i;
                m_iv = (sel >= 0);
                if (sel >= 0) begin
                    m_pl = mq[sel].pl; m_a = mq[sel].a_val; m_b = mq[sel].b_val;
                end
            end
            acc = bus.dispatch_valid && (mq.size() != DEPTH);
            if (bus.cdb_valid) begin
                for (int i = 0; i < mq.size(); i++) begin
                    if (!mq[i].a_rdy && mq[i].a_tag == bus.cdb_tag) begin mq[i].a_rdy = 1'b1; mq[i].a_val = bus.cdb_value; end
                    if (!mq[i].b_rdy && mq[i].b_tag == bus.cdb_tag) begin mq[i].b_rdy = 1'b1; mq[i].b_val = bus.cdb_value; end
                end
            end
            if (sel >= 0) mq.delete(sel);
            if (acc) begin
                e.pl = bus.dispatch_payload;
                e.a_rdy = bus.dispatch_srcA_rdy; e.a_tag = bus.dispatch_srcA_tag; e.a_val = bus.dispatch_srcA_val;
                e.b_rdy = bus.dispatch_srcB_rdy; e.b_tag = bus.dispatch_srcB_tag; e.b_val = bus.dispatch_srcB_val;
                if (bus.cdb_valid && !e.a_rdy && e.a_tag == bus.cdb_tag) begin e.a_rdy = 1'b1; e.a_val = bus.cdb_value; end
                if (bus.cdb_valid && !e.b_rdy && e.b_tag == bus.cdb_tag) begin e.b_rdy = 1'b1; e.b_val = bus.cdb_value; end
                mq.push_back(e);
            end
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge CLK);
        #1;
        chk("issue_valid", PW'(bus.issue_valid), PW'(m_iv));
        chk("issue_payload", bus.issue_payload, m_pl);
        chk("issue_opA", PW'(bus.issue_opA), PW'(m_a));
        chk("issue_opB", PW'(bus.issue_opB), PW'(m_b));
        chk("occupancy", PW'(occupancy), PW'(mq.size()));
        chk("dispatch_ready", PW'(bus.dispatch_ready), PW'(mq.size() != DEPTH));
    endtask

    task automatic idle();
        bus.dispatch_valid = 1'b0;
        bus.cdb_valid      = 1'b0;
        flush              = 1'b0;
    endtask

    task automatic disp(input logic ar, input logic [TW-1:0] at, input logic [31:0] av,
                        input logic br, input logic [TW-1:0] bt, input logic [31:0] bv);
        last_pl                = rand_pl();
        bus.dispatch_valid     = 1'b1;
        bus.dispatch_payload   = last_pl;
        bus.dispatch_srcA_rdy  = ar; bus.dispatch_srcA_tag = at; bus.dispatch_srcA_val = av;
        bus.dispatch_srcB_rdy  = br; bus.dispatch_srcB_tag = bt; bus.dispatch_srcB_val = bv;
    endtask

    task automatic cdb(input logic [TW-1:0] t, input logic [31:0] v);
        bus.cdb_valid = 1'b1; bus.cdb_tag = t; bus.cdb_value = v;
    endtask

    initial begin
        RESET = 1'b1; flush = 1'b0; bus.issue_stall = 1'b0;
        idle();
        disp(1'b0, '0, '0, 1'b0, '0, '0);
        bus.dispatch_valid = 1'b0;
        bus.cdb_tag = '0; bus.cdb_value = '0;
        tick(); tick();
        chk("reset_occupancy", PW'(occupancy), '0);
        RESET = 1'b0;

        // Both operands ready at dispatch
        disp(1'b1, 6'd1, 32'h5, 1'b1, 6'd2, 32'h7); p[0] = last_pl; tick();
        idle(); tick();
        chk("t1_valid", PW'(bus.issue_valid), PW'(1));
        chk("t1_opA", PW'(bus.issue_opA), PW'(32'h5));
        chk("t1_opB", PW'(bus.issue_opB), PW'(32'h7));
        chk("t1_occ", PW'(occupancy), '0);
        tick();

        // Oldest entry waits on tag 3; younger ready entries bypass it
        disp(1'b0, 6'd3, '0, 1'b1, 6'd4, 32'h11); p[0] = last_pl; tick();
        disp(1'b1, 6'd5, 32'h21, 1'b1, 6'd6, 32'h22); p[1] = last_pl; tick();
        disp(1'b1, 6'd7, 32'h31, 1'b1, 6'd8, 32'h32); p[2] = last_pl; tick();
        chk("t2_first", bus.issue_payload, p[1]);
        idle(); tick();
        chk("t2_second", bus.issue_payload, p[2]);
        tick();
        cdb(6'd3, 32'hDEAD); tick();
        idle(); tick();
        chk("t2_woken_opA", PW'(bus.issue_opA), PW'(32'hDEAD));
        chk("t2_woken_pl", bus.issue_payload, p[0]);
        tick();

        // Fill with waiting entries, then wake the middle one
        for (int k = 0; k < DEPTH; k++) begin
            disp(1'b0, TW'(16 + k), '0, 1'b1, 6'd0, 32'(k)); p[k] = last_pl; tick();
        end
        chk("t3_full_occ", PW'(occupancy), PW'(DEPTH));
        chk("t3_full_rdy", PW'(bus.dispatch_ready), '0);
        disp(1'b1, 6'd1, 32'h99, 1'b1, 6'd1, 32'h98); tick();
        idle(); cdb(6'd20, 32'h4444); tick();
        idle(); tick();
        chk("t3_mid_pl", bus.issue_payload, p[4]);
        chk("t3_mid_rdy", PW'(bus.dispatch_ready), PW'(1));
        cdb(6'd21, 32'h5555); tick();
        idle(); tick();
        chk("t3_shift_pl", bus.issue_payload, p[5]);
        flush = 1'b1; tick();
        idle();

        // Same-cycle dispatch and broadcast of its producer tag
        disp(1'b0, 6'd9, '0, 1'b1, 6'd2, 32'h77); cdb(6'd9, 32'h1234); tick();
        idle(); tick();
        chk("t4_opA", PW'(bus.issue_opA), PW'(32'h1234));
        tick();

        // Stall with two ready entries resident
        bus.issue_stall = 1'b1;
        disp(1'b1, 6'd1, 32'hA1, 1'b1, 6'd2, 32'hA2); p[0] = last_pl; tick();
        disp(1'b1, 6'd1, 32'hB1, 1'b1, 6'd2, 32'hB2); p[1] = last_pl; tick();
        idle();
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("t5_stall_occ", PW'(occupancy), PW'(2));
            chk("t5_stall_valid", PW'(bus.issue_valid), '0);
        end
        bus.issue_stall = 1'b0; tick();
        chk("t5_first", bus.issue_payload, p[0]);
        tick();
        chk("t5_second", bus.issue_payload, p[1]);
        tick();

        // Flush beats a same-cycle dispatch
        for (int k = 0; k < 5; k++) begin
            disp(1'b0, TW'(40 + k), '0, 1'b1, 6'd0, '0); tick();
        end
        disp(1'b1, 6'd1, 32'hC1, 1'b1, 6'd2, 32'hC2); flush = 1'b1; tick();
        chk("t6_flush_occ", PW'(occupancy), '0);
        chk("t6_flush_valid", PW'(bus.issue_valid), '0);
        idle(); tick();
        chk("t6_dropped", PW'(bus.issue_valid), '0);

        // Reset during a stall clears the held issue register
        disp(1'b1, 6'd1, 32'hE1, 1'b1, 6'd2, 32'hE2); tick();
        idle(); tick();
        bus.issue_stall = 1'b1; tick();
        RESET = 1'b1; tick();
        chk("t6_rst_valid", PW'(bus.issue_valid), '0);
        chk("t6_rst_pl", bus.issue_payload, '0);
        chk("t6_rst_opA", PW'(bus.issue_opA), '0);
        RESET = 1'b0; bus.issue_stall = 1'b0; tick();

        // Randomized traffic
        for (int n = 0; n < 500; n++) begin
            idle();
            if ($urandom_range(99) < 60)
                disp(1'($urandom_range(1)), TW'($urandom_range(15)), $urandom(),
                     1'($urandom_range(1)), TW'($urandom_range(15)), $urandom());
            if ($urandom_range(99) < 40) cdb(TW'($urandom_range(15)), $urandom());
            bus.issue_stall = ($urandom_range(99) < 20);
            flush           = ($urandom_range(99) < 2);
            RESET           = ($urandom_range(199) == 0);
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
